// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with built-in ALU decoder.
// Ports: clk, reset_n, op, funct, zero -> mux selects, write enables, pcen, illegal_op, state_o.
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state, state_n;
  aluop_t aluop;
  logic   pcwrite, branch;
  logic   irw, memw, regw;
  logic   op_ok, funct_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_n;
  end

  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW,
      OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
      default:               op_ok = 1'b0;
    endcase
  end

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b101010: funct_ok = 1'b1;
      default:              funct_ok = 1'b0;
    endcase
  end

  // Sticky: latched on the edge that leaves DECODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      illegal_op <= 1'b0;
    else if (state == S_DECODE &&
             (!op_ok || (op == OP_RTYPE && !funct_ok)))
      illegal_op <= 1'b1;
  end

  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXECUTE;
          OP_BEQ:       state_n = S_BRANCH;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JUMP;
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR:  state_n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_n = S_MEMWB;
      S_EXECUTE: state_n = S_ALUWB;
      S_ADDIEX:  state_n = S_ADDIWB;
      default:   state_n = S_FETCH;
    endcase
  end

  always_comb begin
    aluop    = AOP_ADD;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    irw      = 1'b0;
    memw     = 1'b0;
    regw     = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state)
      S_FETCH: begin
        irw     = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regw     = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        memw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = AOP_FUNCT;
      end
      S_ALUWB: begin
        regw   = 1'b1;
        regdst = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regw = 1'b1;
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      AOP_SUB: alucontrol = 3'b110;
      AOP_FUNCT: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Enables are masked while reset is held so nothing writes
  // during the combinational FETCH decode seen under reset.
  assign irwrite  = irw  & reset_n;
  assign memwrite = memw & reset_n;
  assign regwrite = regw & reset_n;
  assign pcen     = (pcwrite | (branch & zero)) & reset_n;
  assign state_o  = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller.
// Hand-computed state sequences and control values per instruction.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       iord, regdst, memtoreg;
  logic       irwrite, memwrite, regwrite, pcen;
  logic       illegal_op;
  logic [3:0] state_o;

  int nchk = 0;
  int nfail = 0;

  mips_mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct),
    .zero(zero), .alucontrol(alucontrol), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .iord(iord),
    .regdst(regdst), .memtoreg(memtoreg), .irwrite(irwrite),
    .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run from FETCH until back in FETCH; check cycle count.
  task automatic run_instr(input string tag,
                           input logic [5:0] o,
                           input logic [5:0] f,
                           input int ncyc);
    int n;
    op = o;
    funct = f;
    n = 0;
    do begin
      tick();
      n++;
    end while (state_o != 4'd0 && n < 10);
    check(tag, n, ncyc);
  endtask

  logic [3:0] lw_seq [6];
  logic [5:0] ops [10];
  int         cyc [10];

  initial begin
    lw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ops = '{6'b001000, 6'b100011, 6'b101011, 6'b000000,
            6'b000100, 6'b000010, 6'b001000, 6'b000000,
            6'b100011, 6'b000100};
    cyc = '{4, 5, 4, 4, 3, 3, 4, 4, 5, 3};

    reset_n = 1'b0;
    op = 6'b100011;
    funct = 6'b000000;
    zero = 1'b0;
    #2;
    check("rst_state", state_o, 0);
    check("rst_irwrite", irwrite, 0);
    check("rst_pcen", pcen, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_alusrcb", alusrcb, 2'b01);
    #10;
    reset_n = 1'b1;
    #1;
    check("fetch_irwrite", irwrite, 1);
    check("fetch_pcen", pcen, 1);
    check("fetch_alu", alucontrol, 3'b010);

    // lw
    for (int i = 0; i < 6; i++) begin
      check("lw_state", state_o, lw_seq[i]);
      check("lw_memwrite", memwrite, 0);
      check("lw_regwrite", regwrite, i == 4);
      check("lw_memtoreg", memtoreg, i == 4);
      if (i == 1) check("lw_dec_srcb", alusrcb, 2'b11);
      if (i == 2) check("lw_adr_srcb", alusrcb, 2'b10);
      if (i == 3) check("lw_rd_iord", iord, 1);
      if (i < 5) tick();
    end

    // R-type slt
    op = 6'b000000;
    funct = 6'b101010;
    tick();
    tick();
    check("r_ex_state", state_o, 6);
    check("r_ex_alu", alucontrol, 3'b111);
    check("r_ex_srca", alusrca, 1);
    tick();
    check("r_wb_state", state_o, 7);
    check("r_wb_regwrite", regwrite, 1);
    check("r_wb_regdst", regdst, 1);
    tick();
    check("r_done", state_o, 0);

    // beq taken / not taken
    for (int z = 1; z >= 0; z--) begin
      op = 6'b000100;
      zero = z[0];
      tick();
      tick();
      check("beq_state", state_o, 8);
      check("beq_alu", alucontrol, 3'b110);
      check("beq_pcsrc", pcsrc, 2'b01);
      check("beq_pcen", pcen, z[0]);
      tick();
      check("beq_done", state_o, 0);
    end
    zero = 1'b0;

    // j
    op = 6'b000010;
    tick();
    tick();
    check("j_state", state_o, 11);
    check("j_pcsrc", pcsrc, 2'b10);
    check("j_pcen", pcen, 1);
    tick();
    check("j_done", state_o, 0);

    // sw aborted by reset in MEMWR
    op = 6'b101011;
    tick();
    tick();
    tick();
    check("sw_state", state_o, 5);
    check("sw_memwrite", memwrite, 1);
    check("sw_iord", iord, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_memwrite", memwrite, 0);
    check("abort_state", state_o, 0);
    check("abort_irwrite", irwrite, 0);
    check("abort_pcen", pcen, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_irwrite", irwrite, 1);
    check("rel_pcen", pcen, 1);
    run_instr("sw_cycles", 6'b101011, 6'b100000, 4);

    // addi
    op = 6'b001000;
    tick();
    tick();
    check("addi_ex_state", state_o, 9);
    check("addi_ex_srcb", alusrcb, 2'b10);
    tick();
    check("addi_wb_state", state_o, 10);
    check("addi_wb_regw", regwrite, 1);
    check("addi_wb_regdst", regdst, 0);
    tick();

    // unsupported opcode
    op = 6'b111111;
    check("illegal_pre", illegal_op, 0);
    tick();
    check("bad_dec", state_o, 1);
    check("bad_not_yet", illegal_op, 0);
    tick();
    check("bad_back", state_o, 0);
    check("bad_flag", illegal_op, 1);

    for (int i = 0; i < 10; i++) begin
      run_instr("legal_cycles", ops[i], 6'b100000, cyc[i]);
      check("illegal_sticky", illegal_op, 1);
    end

    // unsupported funct behaves as add
    op = 6'b000000;
    funct = 6'b000011;
    tick();
    tick();
    check("badf_alu", alucontrol, 3'b010);
    tick();
    tick();
    check("badf_done", state_o, 0);

    // unsupported funct alone sets the flag
    reset_n = 1'b0;
    #2;
    check("rst2_illegal", illegal_op, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_instr("badf_cycles", 6'b000000, 6'b000011, 4);
    check("badf_flag", illegal_op, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
